// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding, interrupt ID width and overrun counter width.
package intc_pkg;

    localparam int ID_W  = 4;
    localparam int OVR_W = 8;

    localparam logic [7:0] OFF_IPEND = 8'h00;
    localparam logic [7:0] OFF_IMASK = 8'h04;
    localparam logic [7:0] OFF_ISTAT = 8'h08;
    localparam logic [7:0] OFF_IEOI  = 8'h0C;
    localparam logic [7:0] OFF_IOVR  = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INSVC = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] cand,
    output logic [ID_W-1:0] sel,
    output logic            any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) sel = ID_W'(i);
        end
        any = |cand;
    end

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: rising-edge latched pending bits,
// mask register, single prioritised req/ack request, EOI release.
// Optional feature macro: INTC_OVERRUN_EN adds the IOVR overrun counter.
module intr_controller
    import intc_pkg::*;
#(
    parameter int                    ABUS_WIDTH = 32,
    parameter int                    DBUS_WIDTH = 32,
    parameter int                    NSRC       = 4,
    parameter logic [ABUS_WIDTH-1:0] BASE_ADDR  = 32'hF0000800
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ABUS_WIDTH-1:0] aBus,
    inout  wire  [DBUS_WIDTH-1:0] dBus,
    input  logic                  wrtEn,
    input  logic                  IE,
    input  logic [NSRC-1:0]       irq_src,
    output logic                  intr_req,
    output logic [ID_W-1:0]       intr_id,
    input  logic                  intr_ack
);

    localparam logic [ABUS_WIDTH-1:0] A_IPEND = BASE_ADDR + ABUS_WIDTH'(OFF_IPEND);
    localparam logic [ABUS_WIDTH-1:0] A_IMASK = BASE_ADDR + ABUS_WIDTH'(OFF_IMASK);
    localparam logic [ABUS_WIDTH-1:0] A_ISTAT = BASE_ADDR + ABUS_WIDTH'(OFF_ISTAT);
    localparam logic [ABUS_WIDTH-1:0] A_IEOI  = BASE_ADDR + ABUS_WIDTH'(OFF_IEOI);
    localparam logic [ABUS_WIDTH-1:0] A_IOVR  = BASE_ADDR + ABUS_WIDTH'(OFF_IOVR);

    logic [NSRC-1:0] src_q, src_d, pend_q, pend_d, mask_q, mask_d;
    logic [NSRC-1:0] rise, cand, clr_v;
    intc_state_e     state_q, state_d;
    logic            intr_req_q, intr_req_d;
    logic [ID_W-1:0] intr_id_q, intr_id_d, sel;
    logic            any;
    logic [OVR_W-1:0] ovr_val;
    logic [DBUS_WIDTH-1:0] rd_data;
    logic            rd_en;
    logic            unused_dbus;

    wire hit_ipend = (aBus == A_IPEND);
    wire hit_imask = (aBus == A_IMASK);
    wire hit_istat = (aBus == A_ISTAT);
    wire hit_ieoi  = (aBus == A_IEOI);
    wire hit_iovr  = (aBus == A_IOVR);
    wire wr_ipend  = wrtEn & hit_ipend;
    wire wr_imask  = wrtEn & hit_imask;
    wire wr_ieoi   = wrtEn & hit_ieoi;
    wire ack_fire  = (state_q == ST_REQ) & intr_ack;

    // Only the low NSRC data bits carry register content on writes
    assign unused_dbus = ^dBus[DBUS_WIDTH-1:NSRC];

    assign rise = irq_src & ~src_q;
    assign cand = pend_q & mask_q;

    intc_prio_enc #(.NSRC(NSRC)) u_prio (
        .cand (cand),
        .sel  (sel),
        .any  (any)
    );

    // Next-state: edge capture, W1C/ack clears (new edges win), mask, request FSM
    always_comb begin
        src_d = irq_src;
        clr_v = wr_ipend ? dBus[NSRC-1:0] : '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ack_fire && intr_id_q == ID_W'(i)) clr_v[i] = 1'b1;
        end
        pend_d     = (pend_q & ~clr_v) | rise;
        mask_d     = wr_imask ? dBus[NSRC-1:0] : mask_q;
        state_d    = state_q;
        intr_req_d = intr_req_q;
        intr_id_d  = intr_id_q;
        case (state_q)
            ST_IDLE: if (IE && any) begin
                state_d    = ST_REQ;
                intr_req_d = 1'b1;
                intr_id_d  = sel;
            end
            // ID stays frozen and IE is ignored until the CPU acks
            ST_REQ: if (intr_ack) begin
                state_d    = ST_INSVC;
                intr_req_d = 1'b0;
            end
            ST_INSVC: if (wr_ieoi) state_d = ST_IDLE;
            default: begin
                state_d    = ST_IDLE;
                intr_req_d = 1'b0;
            end
        endcase
    end

    // Register all controller state; FSM outputs are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            state_q    <= ST_IDLE;
            intr_req_q <= 1'b0;
            intr_id_q  <= '0;
        end else begin
            src_q      <= src_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            intr_req_q <= intr_req_d;
            intr_id_q  <= intr_id_d;
        end
    end

`ifdef INTC_OVERRUN_EN
    logic [OVR_W-1:0] ovr_q, ovr_d;
    wire wr_iovr = wrtEn & hit_iovr;

    // Saturating count of edges that land on an already-pending source
    always_comb begin
        ovr_d = ovr_q;
        if (wr_iovr)
            ovr_d = '0;
        else if (|(rise & pend_q) && ovr_q != '1)
            ovr_d = ovr_q + 1'b1;
    end

    // Overrun counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_q <= '0;
        else       ovr_q <= ovr_d;
    end

    assign ovr_val = ovr_q;
`else
    assign ovr_val = '0;
`endif

    // Read mux: drive the bus only for reads of our own registers
    always_comb begin
        rd_data = '0;
        rd_en   = ~wrtEn & (hit_ipend | hit_imask | hit_istat | hit_ieoi | hit_iovr);
        if (hit_ipend)      rd_data[NSRC-1:0]  = pend_q;
        else if (hit_imask) rd_data[NSRC-1:0]  = mask_q;
        else if (hit_istat) rd_data[5:0]       = {state_q, intr_id_q};
        else if (hit_iovr)  rd_data[OVR_W-1:0] = ovr_val;
    end

    assign dBus     = rd_en ? rd_data : 'z;
    assign intr_req = intr_req_q;
    assign intr_id  = intr_id_q;

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: stimulus pushes expected values,
// a negedge monitor pops and compares bus reads or request outputs.
module tb_intr_controller;

    localparam logic [31:0] BASE  = 32'hF0000800;
    localparam logic [31:0] IPEND = BASE + 32'h00;
    localparam logic [31:0] IMASK = BASE + 32'h04;
    localparam logic [31:0] ISTAT = BASE + 32'h08;
    localparam logic [31:0] IEOI  = BASE + 32'h0C;
    localparam logic [31:0] IOVR  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aBus;
    wire  [31:0] dBus;
    logic        wrtEn, IE, intr_ack;
    logic [3:0]  irq_src;
    logic        intr_req;
    logic [3:0]  intr_id;
    logic [31:0] tb_d;
    logic        tb_oe;

    typedef struct {
        string       name;
        bit          kind;   // 0: bus read value, 1: {intr_req, intr_id}
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    logic mon_vld = 1'b0;
    int   checks = 0;
    int   errors = 0;

    assign dBus = tb_oe ? tb_d : 'z;

    always #5 clk = ~clk;

    intr_controller dut (
        .clk      (clk),
        .reset    (reset),
        .aBus     (aBus),
        .dBus     (dBus),
        .wrtEn    (wrtEn),
        .IE       (IE),
        .irq_src  (irq_src),
        .intr_req (intr_req),
        .intr_id  (intr_id),
        .intr_ack (intr_ack)
    );

    // Monitor: compare whenever the stimulus presents an observation
    always @(negedge clk) begin
        if (mon_vld) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: observation with no expected value");
            end else begin
                exp_t e;
                logic [31:0] act;
                e   = sb.pop_front();
                act = e.kind ? {27'd0, intr_req, intr_id} : dBus;
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        aBus = a; tb_d = d; tb_oe = 1'b1; wrtEn = 1'b1;
        cyc();
        wrtEn = 1'b0; tb_oe = 1'b0; aBus = 32'h0;
    endtask

    task automatic observe(input string n, input bit k, input logic [31:0] e);
        exp_t x;
        x.name = n; x.kind = k; x.exp = e;
        sb.push_back(x);
        mon_vld = 1'b1;
        @(negedge clk);
        #1;
        mon_vld = 1'b0;
    endtask

    task automatic expect_bus(input logic [31:0] a, input logic [31:0] e, input string n);
        aBus = a; wrtEn = 1'b0;
        observe(n, 1'b0, e);
        cyc();
        aBus = 32'h0;
    endtask

    task automatic expect_req(input logic r, input logic [3:0] id, input string n);
        observe(n, 1'b1, {27'd0, r, id});
        cyc();
    endtask

    task automatic ack();
        intr_ack = 1'b1;
        cyc();
        intr_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; aBus = '0; wrtEn = 1'b0; IE = 1'b1; intr_ack = 1'b0;
        irq_src = '0; tb_d = '0; tb_oe = 1'b0;
        #2;
        expect_req(1'b0, 4'd0, "reset_req");
        expect_bus(IPEND, 32'h0, "reset_ipend");
        reset = 1'b0;
        cyc();

        // 1: single source, two-cycle latency, ack clears pending
        wr(IMASK, 32'h1);
        irq_src = 4'h1; cyc(); irq_src = 4'h0;
        expect_req(1'b0, 4'd0, "t1_not_yet");
        expect_req(1'b1, 4'd0, "t1_req");
        expect_bus(IPEND, 32'h1, "t1_pend");
        expect_bus(ISTAT, 32'h10, "t1_stat_req");
        ack();
        expect_bus(IPEND, 32'h0, "t1_pend_clr");
        expect_bus(ISTAT, 32'h20, "t1_stat_insvc");
        expect_req(1'b0, 4'd0, "t1_req_drop");
        wr(IEOI, 32'h0);
        expect_bus(ISTAT, 32'h00, "t1_stat_idle");

        // 2: simultaneous sources, lowest index first, next after EOI
        wr(IMASK, 32'h6);
        irq_src = 4'h6; cyc(); cyc();
        expect_req(1'b1, 4'd1, "t2_first");
        ack();
        expect_req(1'b0, 4'd1, "t2_insvc");
        expect_bus(IPEND, 32'h4, "t2_pend");
        wr(IEOI, 32'h0);
        cyc();
        expect_req(1'b1, 4'd2, "t2_second");
        irq_src = 4'h0;
        ack();
        wr(IEOI, 32'h0);
        expect_bus(IEOI, 32'h0, "t2_ieoi_read");

        // 3: masked source stays pending; stray ack ignored; unmask raises request
        wr(IMASK, 32'h0);
        irq_src = 4'h8; cyc(); irq_src = 4'h0;
        ack();
        expect_req(1'b0, 4'd2, "t3_masked");
        expect_bus(IPEND, 32'h8, "t3_pend");
        wr(IMASK, 32'h8);
        cyc();
        expect_req(1'b1, 4'd3, "t3_unmask_req");
        expect_bus(IMASK, 32'h8, "t3_mask");
        ack();
        wr(IEOI, 32'h0);

        // 4: set beats W1C in the same cycle; ISTAT and unmapped writes ignored
        irq_src = 4'h4;
        wr(IPEND, 32'h4);
        irq_src = 4'h0;
        expect_bus(IPEND, 32'h4, "t4_set_wins");
        wr(IPEND, 32'h4);
        expect_bus(IPEND, 32'h0, "t4_w1c");
        wr(ISTAT, 32'h3F);
        expect_bus(ISTAT, 32'h03, "t4_istat_ro");
        wr(BASE + 32'h20, 32'hF);
        expect_bus(IMASK, 32'h8, "t4_unmapped");

        // 5: async reset during REQ clears outputs without a clock edge
        wr(IMASK, 32'h2);
        irq_src = 4'h2; cyc(); irq_src = 4'h0; cyc();
        expect_req(1'b1, 4'd1, "t5_req");
        reset = 1'b1;
        expect_req(1'b0, 4'd0, "t5_async_rst");
        reset = 1'b0;
        expect_bus(ISTAT, 32'h0, "t5_stat");
        expect_bus(IPEND, 32'h0, "t5_pend");
        expect_bus(IMASK, 32'h0, "t5_mask");

        // 6: overrun counter
        for (int i = 0; i < 3; i++) begin
            irq_src = 4'h1; cyc();
            irq_src = 4'h0; cyc();
        end
`ifdef INTC_OVERRUN_EN
        expect_bus(IOVR, 32'h2, "t6_iovr");
`else
        expect_bus(IOVR, 32'h0, "t6_iovr");
`endif
        wr(IOVR, 32'h0);
        expect_bus(IOVR, 32'h0, "t6_iovr_clr");

        // IE gating: pending unmasked source waits for IE
        IE = 1'b0;
        wr(IMASK, 32'h1);
        cyc();
        expect_req(1'b0, 4'd0, "ie_low");
        IE = 1'b1;
        cyc();
        expect_req(1'b1, 4'd0, "ie_high");
        ack();

        repeat (2) cyc();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
